cmd_sequencer: RTL and testbench
================================

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL have parameter NUM_CMDS, default 4, number of commands issued per sequence (1..2^CMD_W).
REQ-002 SHALL have parameter CMD_W, default 3, command code width.
REQ-003 SHALL have parameter GAP_W, default 28, inter-command gap counter width.
REQ-004 SHALL have parameter DAT_W, default 11, data-pulse counter width.
REQ-005 SHALL have parameter TO_CYC, default 65535, handshake timeout in cycles.
REQ-006 SHALL have these ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_in  in  1  sequence request, sampled in IDLE only.
- abort  in  1  synchronous abort.
- mode_loop  in  1  1 = restart the sequence after DONE.
- gap_cycles  in  GAP_W  delay after each command completes; latched at start.
- data_cycles  in  DAT_W  data_start pulse length; latched at start.
- cmd_out  out  CMD_W  current command index.
- cmd_start  out  1  command request.
- cmd_ready  in  1  executor status: low = acknowledged/busy, high = complete.
- link_busy  in  1  link busy; holds the data phase.
- data_start  out  1  data engine start.
- data_busy  in  1  data engine busy.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on sequence completion.
- error  out  1  sticky timeout flag; cleared at the next accepted start.

Function
REQ-007 SHALL implement states IDLE, ISSUE, WAIT_ACK, WAIT_CMP, GAP, WAIT_LINK, DATA, WAIT_DATA, DONE.
REQ-008 IDLE: on start_in=1, SHALL latch gap_cycles and data_cycles, set cmd_out=0, clear error, and go to ISSUE.
REQ-009 ISSUE: SHALL assert cmd_start=1 and go to WAIT_ACK; cmd_start is visible the cycle after start_in is sampled.
REQ-010 WAIT_ACK: SHALL hold cmd_start=1 and move to WAIT_CMP when cmd_ready=0.
REQ-011 WAIT_CMP: SHALL deassert cmd_start and move to GAP when cmd_ready=1.
REQ-012 cmd_out SHALL stay stable from ISSUE through GAP.
REQ-013 GAP: SHALL count gap_cycles cycles; gap 0 means zero extra cycles. At expiry:
- if cmd_out < NUM_CMDS-1, increment cmd_out and go to ISSUE;
- otherwise go to WAIT_LINK.
REQ-014 WAIT_LINK: SHALL go to DATA when link_busy=0. If data_cycles=0, SHALL go directly to DONE instead.
REQ-015 DATA: SHALL assert data_start for data_cycles counted cycles, then go to WAIT_DATA.
- While link_busy=1, data_start SHALL be 0 and the count SHALL pause.
REQ-016 WAIT_DATA: SHALL go to DONE once data_busy has been seen 1 and then 0; an already-high data_busy counts as seen.
REQ-017 DONE: SHALL pulse done for exactly one cycle.
- mode_loop=1: set cmd_out=0 and go to ISSUE, reusing the latched values.
- mode_loop=0: go to IDLE.
REQ-018 WAIT_ACK, WAIT_CMP and WAIT_DATA SHALL each time out after TO_CYC cycles. On timeout: set error=1, drive all outputs inactive, go to IDLE, and do not pulse done.
REQ-019 abort=1 in any state SHALL force IDLE on the next edge.
- cmd_start, data_start and busy SHALL read 0 the following cycle; no done pulse.
- abort takes priority over start_in and over timeout.
REQ-020 start_in SHALL be ignored outside IDLE.
REQ-021 Counters SHALL count down without wrap-around, saturating at 0.
REQ-022 cmd_out increment SHALL never exceed NUM_CMDS-1.

Reset
REQ-023 With rst=0, state SHALL be IDLE and all outputs SHALL be 0: cmd_out, cmd_start, data_start, busy, done, error.
REQ-024 All counters and latched values SHALL clear to 0 on reset.
REQ-025 Reset mid-sequence SHALL take effect immediately (asynchronous assertion) and SHALL not pulse done.

Structure
REQ-026 Package cmd_seq_pkg SHALL hold the state encoding constants and the default parameter values.
REQ-027 Package cmd_seq_pkg SHALL also hold the timeout-width derivation (clog2 of TO_CYC).
REQ-028 SHALL instantiate one sub-module, cmd_seq_timer: loadable, pausable down-counter with an expiry flag.
REQ-029 cmd_seq_timer SHALL be shared by the GAP, DATA and timeout functions.

Verification
REQ-030 NUM_CMDS=4, gap=3, data=5, well-behaved executor -> cmd_out 0..3 each handshaken, 3 idle gap cycles after each, data_start high 5 cycles, one done pulse, busy drops.
REQ-031 link_busy=1 for 2 cycles mid-DATA -> data_start low for those cycles; total data_start high count still 5.
REQ-032 cmd_ready stuck high in WAIT_ACK, TO_CYC=16 -> error=1 after 16 cycles, IDLE, no done; next start_in clears error.
REQ-033 mode_loop=1 -> done pulses, then cmd_out restarts at 0 with no idle gap; abort mid-GAP -> all outputs 0 next cycle.
REQ-034 Reset asserted during WAIT_DATA -> all outputs 0 immediately; gap=0 and data=0 -> back-to-back ISSUE, done right after WAIT_LINK.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// Command sequencer shared definitions:
// state encoding, default parameters and width helpers.
package cmd_seq_pkg;

    localparam int NUM_CMDS_DEF = 4;
    localparam int CMD_W_DEF    = 3;
    localparam int GAP_W_DEF    = 28;
    localparam int DAT_W_DEF    = 11;
    localparam int TO_CYC_DEF   = 65535;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ISSUE     = 4'd1;
    localparam logic [3:0] S_WAIT_ACK  = 4'd2;
    localparam logic [3:0] S_WAIT_CMP  = 4'd3;
    localparam logic [3:0] S_GAP       = 4'd4;
    localparam logic [3:0] S_WAIT_LINK = 4'd5;
    localparam logic [3:0] S_DATA      = 4'd6;
    localparam logic [3:0] S_WAIT_DATA = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    // Timeout counter holds TO_CYC-1, which always fits in clog2(TO_CYC)
    function automatic int to_width(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cmd_seq_timer.sv
// Loadable, pausable down-counter that saturates at zero
// and flags expiry when the count reaches zero.
module cmd_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cmd_sequencer.sv
// Issues NUM_CMDS handshaken commands with programmable gaps,
// then a pausable data-start pulse; optional looping.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int NUM_CMDS = NUM_CMDS_DEF,
    parameter int CMD_W    = CMD_W_DEF,
    parameter int GAP_W    = GAP_W_DEF,
    parameter int DAT_W    = DAT_W_DEF,
    parameter int TO_CYC   = TO_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic             abort,
    input  logic             mode_loop,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic [DAT_W-1:0] data_cycles,
    output logic [CMD_W-1:0] cmd_out,
    output logic             cmd_start,
    input  logic             cmd_ready,
    input  logic             link_busy,
    output logic             data_start,
    input  logic             data_busy,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int TO_W = to_width(TO_CYC);
    localparam int TW   = max3(GAP_W, DAT_W, TO_W);

    localparam logic [TW-1:0]    TO_LOAD  = TW'(TO_CYC - 1);
    localparam logic [CMD_W-1:0] LAST_CMD = CMD_W'(NUM_CMDS - 1);

    logic [3:0]       state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic             err_q, err_d;
    logic             seen_q, seen_d;
    logic             adv, tmo;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0]    tmr_val;

    cmd_seq_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        gap_d    = gap_q;
        dat_d    = dat_q;
        err_d    = err_q;
        seen_d   = seen_q;
        adv      = 1'b0;
        tmo      = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    gap_d   = gap_cycles;
                    dat_d   = data_cycles;
                    cmd_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_load = 1'b1;
                tmr_val  = TO_LOAD;
                state_d  = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!cmd_ready) begin
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
                    state_d  = S_WAIT_CMP;
                end else if (tmr_zero) begin
                    tmo = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_WAIT_CMP: begin
                // A zero gap skips GAP entirely so ISSUE follows at once
                if (cmd_ready) begin
                    if (gap_q == '0) begin
                        adv = 1'b1;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = TW'(gap_q) - TW'(1);
                        state_d  = S_GAP;
                    end
                end else if (tmr_zero) begin
                    tmo = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_zero) adv = 1'b1;
                else tmr_dec = 1'b1;
            end
            S_WAIT_LINK: begin
                if (dat_q == '0) begin
                    state_d = S_DONE;
                end else if (!link_busy) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(dat_q) - TW'(1);
                    seen_d   = 1'b0;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (data_busy) seen_d = 1'b1;
                if (!link_busy) begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        tmr_val  = TO_LOAD;
                        state_d  = S_WAIT_DATA;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (data_busy) seen_d = 1'b1;
                if (seen_q && !data_busy) begin
                    state_d = S_DONE;
                end else if (tmr_zero) begin
                    tmo = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_DONE: begin
                cmd_d   = '0;
                state_d = mode_loop ? S_ISSUE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (adv) begin
            if (cmd_q < LAST_CMD) begin
                cmd_d   = cmd_q + CMD_W'(1);
                state_d = S_ISSUE;
            end else begin
                state_d = S_WAIT_LINK;
            end
        end

        if (tmo) begin
            err_d   = 1'b1;
            cmd_d   = '0;
            state_d = S_IDLE;
        end

        // Abort outranks both a same-cycle start and a timeout
        if (abort) begin
            state_d  = S_IDLE;
            cmd_d    = '0;
            gap_d    = gap_q;
            dat_d    = dat_q;
            err_d    = err_q;
            seen_d   = seen_q;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            gap_q   <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            gap_q   <= gap_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
        end
    end

    assign cmd_out    = cmd_q;
    assign cmd_start  = (state_q == S_ISSUE) ||
                        (state_q == S_WAIT_ACK);
    assign data_start = (state_q == S_DATA) && !link_busy;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign error      = err_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: scripted vectors, corner sequences
// and randomized runs scored against a transaction-level model.
module tb_cmd_sequencer;

    localparam int NUM    = 4;
    localparam int CMD_W  = 3;
    localparam int GAP_W  = 28;
    localparam int DAT_W  = 11;
    localparam int TO_CYC = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start_in = 1'b0;
    logic             abort = 1'b0;
    logic             mode_loop = 1'b0;
    logic [GAP_W-1:0] gap_cycles = '0;
    logic [DAT_W-1:0] data_cycles = '0;
    logic [CMD_W-1:0] cmd_out;
    logic             cmd_start;
    logic             cmd_ready = 1'b1;
    logic             link_busy = 1'b0;
    logic             data_start;
    logic             data_busy = 1'b0;
    logic             busy;
    logic             done;
    logic             error;

    always #5 clk = ~clk;

    cmd_sequencer #(
        .NUM_CMDS (NUM),
        .CMD_W    (CMD_W),
        .GAP_W    (GAP_W),
        .DAT_W    (DAT_W),
        .TO_CYC   (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_in    (start_in),
        .abort       (abort),
        .mode_loop   (mode_loop),
        .gap_cycles  (gap_cycles),
        .data_cycles (data_cycles),
        .cmd_out     (cmd_out),
        .cmd_start   (cmd_start),
        .cmd_ready   (cmd_ready),
        .link_busy   (link_busy),
        .data_start  (data_start),
        .data_busy   (data_busy),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    int n_chk = 0;
    int n_pass = 0;

    bit exec_on = 1'b1;
    bit dat_on = 1'b1;
    bit lnk_rand = 1'b0;
    int ack_max = 0;
    int bsy_max = 0;
    int eng_len = 0;

    int n_starts, ds_cnt, done_cnt, cs_cnt;
    int gap_run, gap_err, n_gaps, stab_err, link_err;
    int exp_gap;
    bit acked, prev_cs;
    logic [CMD_W-1:0] prev_cmd;

    typedef struct {
        int gap;
        int data;
        int ack_max;
        int bsy_max;
        bit lrand;
        int e_starts;
        int e_ds;
        int e_gaps;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input int act,
                         input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d",
                      name, act, exp);
    endtask

    function automatic int outs();
        return int'({cmd_out, cmd_start, data_start,
                     busy, done, error});
    endfunction

    task automatic pclk();
        @(posedge clk);
        #1;
    endtask

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    // Executor: acknowledges each request after a random delay,
    // stays busy a random time, then reports completion.
    initial begin : executor
        int st, cnt;
        st = 0;
        cnt = 0;
        forever begin
            pclk();
            if (!exec_on) begin
                st = 0;
            end else begin
                case (st)
                    0: if (cmd_start) begin
                        cnt = $urandom_range(ack_max, 0);
                        st = 1;
                    end
                    1: if (cnt == 0) begin
                        cmd_ready = 1'b0;
                        cnt = $urandom_range(bsy_max, 0);
                        st = 2;
                    end else begin
                        cnt--;
                    end
                    2: if (!cmd_start) begin
                        if (cnt == 0) begin
                            cmd_ready = 1'b1;
                            st = 0;
                        end else begin
                            cnt--;
                        end
                    end
                    default: st = 0;
                endcase
            end
        end
    end

    initial begin : engine
        int st, cnt;
        st = 0;
        cnt = 0;
        forever begin
            pclk();
            case (st)
                0: if (data_start && dat_on) begin
                    data_busy = 1'b1;
                    cnt = (eng_len > 0) ? eng_len
                                        : $urandom_range(10, 1);
                    st = 1;
                end
                1: if (cnt <= 1) begin
                    data_busy = 1'b0;
                    st = 2;
                end else begin
                    cnt--;
                end
                2: if (!busy) st = 0;
                default: st = 0;
            endcase
        end
    end

    initial begin : link_drv
        forever begin
            pclk();
            if (lnk_rand) link_busy = ($urandom_range(3, 0) == 0);
        end
    end

    // Observes the bus and reduces it to per-sequence facts
    always @(negedge clk) begin
        if (cmd_start) cs_cnt++;
        if (cmd_start && !prev_cs) begin
            n_starts++;
            check("cmd_idx", int'(cmd_out), (n_starts - 1) % NUM);
            if (gap_run > 0) begin
                if (gap_run != exp_gap + 1) gap_err++;
                n_gaps++;
            end
            gap_run = 0;
        end else if (!cmd_start && gap_run > 0) begin
            gap_run++;
        end
        if (cmd_start && prev_cs && cmd_out != prev_cmd) stab_err++;
        if (busy && !cmd_ready) begin
            acked = 1'b1;
        end else if (acked && busy && cmd_ready && !cmd_start) begin
            acked = 1'b0;
            gap_run = 1;
        end
        if (data_start) ds_cnt++;
        if (data_start && link_busy) link_err++;
        if (done) done_cnt++;
        prev_cs = cmd_start;
        prev_cmd = cmd_out;
    end

    task automatic start_seq(input int gap, input int data);
        pclk();
        gap_cycles = GAP_W'(gap);
        data_cycles = DAT_W'(data);
        exp_gap = gap;
        n_starts = 0;
        ds_cnt = 0;
        done_cnt = 0;
        cs_cnt = 0;
        gap_run = 0;
        gap_err = 0;
        n_gaps = 0;
        stab_err = 0;
        link_err = 0;
        acked = 1'b0;
        start_in = 1'b1;
        pclk();
        start_in = 1'b0;
        gap_cycles = GAP_W'($urandom_range(9, 1));
        data_cycles = DAT_W'($urandom_range(9, 1));
        check("cs_next_cycle", int'(cmd_start), 1);
        check("err_cleared", int'(error), 0);
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        do begin
            nclk();
            k++;
        end while (busy && k < bound);
        check("reach_idle", int'(busy), 0);
    endtask

    task automatic finish_seq(input int e_starts, input int e_ds,
                              input int e_gaps);
        wait_idle(600);
        check("n_cmds", n_starts, e_starts);
        check("data_hi_cycles", ds_cnt, e_ds);
        check("done_pulses", done_cnt, 1);
        check("bad_gaps", gap_err, 0);
        check("n_gaps", n_gaps, e_gaps);
        check("cmd_unstable", stab_err, 0);
        check("ds_during_link", link_err, 0);
        check("error_flag", int'(error), 0);
    endtask

    initial begin
        int k, g, d;

        vt[0] = '{3, 5, 0, 0, 1'b0, NUM, 5, NUM - 1};
        vt[1] = '{0, 0, 0, 0, 1'b0, NUM, 0, NUM - 1};
        vt[2] = '{1, 1, 2, 1, 1'b0, NUM, 1, NUM - 1};
        vt[3] = '{0, 3, 3, 3, 1'b1, NUM, 3, NUM - 1};
        vt[4] = '{5, 2, 1, 2, 1'b1, NUM, 2, NUM - 1};

        #3;
        check("reset_outs", outs(), 0);
        start_in = 1'b1;
        repeat (2) @(posedge clk);
        nclk();
        check("reset_hold", outs(), 0);
        start_in = 1'b0;
        rst = 1'b1;
        repeat (2) pclk();

        for (int i = 0; i < 5; i++) begin
            ack_max = vt[i].ack_max;
            bsy_max = vt[i].bsy_max;
            lnk_rand = vt[i].lrand;
            if (!vt[i].lrand) link_busy = 1'b0;
            start_seq(vt[i].gap, vt[i].data);
            finish_seq(vt[i].e_starts, vt[i].e_ds, vt[i].e_gaps);
        end
        lnk_rand = 1'b0;
        link_busy = 1'b0;
        ack_max = 1;
        bsy_max = 1;

        // Link stall for two cycles in the middle of the data pulse
        start_seq(3, 5);
        k = 0;
        while (ds_cnt < 2 && k < 300) begin
            nclk();
            k++;
        end
        check("ds_reached", ds_cnt, 2);
        pclk();
        link_busy = 1'b1;
        nclk();
        check("ds_paused_1", int'(data_start), 0);
        pclk();
        nclk();
        check("ds_paused_2", int'(data_start), 0);
        pclk();
        link_busy = 1'b0;
        finish_seq(NUM, 5, NUM - 1);

        // Executor never acknowledges
        exec_on = 1'b0;
        cmd_ready = 1'b1;
        start_seq(2, 3);
        wait_idle(200);
        check("ack_to_error", int'(error), 1);
        check("ack_to_cs_cycles", cs_cnt, TO_CYC + 1);
        check("ack_to_no_done", done_cnt, 0);
        check("ack_to_cmd_out", int'(cmd_out), 0);
        exec_on = 1'b1;

        start_seq(1, 1);
        finish_seq(NUM, 1, NUM - 1);

        // Data engine never reports busy
        dat_on = 1'b0;
        start_seq(0, 2);
        wait_idle(400);
        check("dat_to_error", int'(error), 1);
        check("dat_to_no_done", done_cnt, 0);
        check("dat_to_ds", ds_cnt, 2);
        dat_on = 1'b1;

        // Looping restart, then abort inside a gap
        mode_loop = 1'b1;
        start_seq(3, 2);
        k = 0;
        while (!done && k < 400) begin
            nclk();
            k++;
        end
        check("loop_done", int'(done), 1);
        nclk();
        check("loop_cs", int'(cmd_start), 1);
        check("loop_idx", int'(cmd_out), 0);
        check("loop_busy", int'(busy), 1);
        k = 0;
        while (gap_run != 2 && k < 200) begin
            nclk();
            k++;
        end
        check("gap_reached", gap_run, 2);
        pclk();
        abort = 1'b1;
        mode_loop = 1'b0;
        pclk();
        abort = 1'b0;
        check("abort_outs", outs(), 0);
        check("abort_no_done", done_cnt, 1);

        pclk();
        abort = 1'b1;
        start_in = 1'b1;
        pclk();
        abort = 1'b0;
        start_in = 1'b0;
        check("abort_over_start", int'(busy), 0);
        repeat (4) pclk();

        // Asynchronous reset while waiting on the data engine
        eng_len = 12;
        start_seq(1, 5);
        k = 0;
        while (!(ds_cnt == 5 && data_busy && !data_start && busy)
               && k < 300) begin
            nclk();
            k++;
        end
        check("wait_data_reached", ds_cnt, 5);
        rst = 1'b0;
        #1;
        check("async_rst_outs", outs(), 0);
        check("async_rst_no_done", done_cnt, 0);
        nclk();
        rst = 1'b1;
        eng_len = 0;
        repeat (20) pclk();

        for (int r = 0; r < 6; r++) begin
            g = $urandom_range(5, 0);
            d = $urandom_range(8, 0);
            ack_max = $urandom_range(3, 0);
            bsy_max = $urandom_range(3, 0);
            lnk_rand = $urandom_range(1, 0) == 1;
            if (!lnk_rand) link_busy = 1'b0;
            start_seq(g, d);
            finish_seq(NUM, d, NUM - 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
